// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock divider.
// Each channel counts 0..div and produces either a 50% toggle clock or a
// one-cycle pulse at terminal count. A two-state handshake FSM captures a
// configuration request in IDLE and applies it to one channel in APPLY.
module multi_clock_divider #(
    parameter int          NUM_CH      = 4,
    parameter int          CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = 50000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [3:0]        cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] out_clk,
    output logic [NUM_CH-1:0] tick
);

    typedef enum logic {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } cfgState_t;

    localparam logic [4:0]       NUM_CH_L   = 5'(NUM_CH);
    localparam logic [CNT_W-1:0] RESET_DIV  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    cfgState_t        r_state;
    cfgState_t        w_nextState;
    logic             w_capture;
    logic             w_applyValid;
    logic             w_chInRange;
    logic [3:0]       r_capCh;
    logic [CNT_W-1:0] r_capDiv;
    logic             r_capMode;

    // The captured channel index is compared against the channel count at
    // full 5-bit width so NUM_CH=16 still treats every 4-bit index as valid.
    assign w_chInRange = ({1'b0, r_capCh} < NUM_CH_L);

    // Configuration FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake outputs: accept in IDLE, apply or flag an error in APPLY.
    always_comb begin
        w_nextState  = r_state;
        cfg_ready    = 1'b0;
        cfg_err      = 1'b0;
        w_capture    = 1'b0;
        w_applyValid = 1'b0;
        case (r_state)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    w_capture   = 1'b1;
                    w_nextState = APPLY;
                end
            end
            APPLY: begin
                w_nextState = IDLE;
                if (w_chInRange) begin
                    w_applyValid = 1'b1;
                end else begin
                    cfg_err = 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Request capture; later changes on the cfg_* inputs cannot disturb a pending apply.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_capCh   <= 4'd0;
            r_capDiv  <= '0;
            r_capMode <= 1'b0;
        end else if (w_capture) begin
            r_capCh   <= cfg_ch;
            r_capDiv  <= cfg_div;
            r_capMode <= cfg_mode;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_div;
        logic             r_mode;
        logic             r_outClk;
        logic             r_tick;
        logic             w_applyHit;
        logic             w_terminal;

        assign w_applyHit = w_applyValid && (r_capCh == 4'(i));
        assign w_terminal = (r_cnt == r_div);
        assign out_clk[i] = r_outClk;
        assign tick[i]    = r_tick;

        // Channel counter and outputs; a configuration apply overrides any
        // terminal count in the same cycle. While disabled, a pulse-mode
        // output drops with tick so the two stay identical.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt    <= '0;
                r_div    <= RESET_DIV;
                r_mode   <= 1'b0;
                r_outClk <= 1'b0;
                r_tick   <= 1'b0;
            end else if (w_applyHit) begin
                r_cnt    <= '0;
                r_div    <= r_capDiv;
                r_mode   <= r_capMode;
                r_outClk <= 1'b0;
                r_tick   <= 1'b0;
            end else if (en[i]) begin
                if (w_terminal) begin
                    r_cnt    <= '0;
                    r_tick   <= 1'b1;
                    r_outClk <= r_mode ? 1'b1 : ~r_outClk;
                end else begin
                    r_cnt    <= r_cnt + CNT_ONE;
                    r_tick   <= 1'b0;
                    r_outClk <= r_mode ? 1'b0 : r_outClk;
                end
            end else begin
                r_tick   <= 1'b0;
                r_outClk <= r_mode ? 1'b0 : r_outClk;
            end
        end
    end

endmodule
